// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue feeding decode.
// Owns the PC and drives a combinational instruction memory. Redirects from decode flush the queue.
module if_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          LIMIT_EN = 1'b0,
    parameter logic [31:0] PC_LIMIT = 32'd84,
    parameter logic [31:0] LOOP_PC  = 32'd80
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         PCSrcD,
    input  logic                         JumpRegD,
    input  logic [31:0]                  PCBranchD,
    input  logic [31:0]                  JRTargetD,
    output logic [IMEM_AW-1:0]           ImemAddr,
    input  logic [31:0]                  ImemRD,
    input  logic                         ReadyD,
    output logic                         InstrValidF,
    output logic [31:0]                  RDF,
    output logic [31:0]                  PCPlus4F,
    output logic [31:0]                  PCF,
    output logic [$clog2(DEPTH+1)-1:0]   QueueCount
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   pc_r;

    logic          redirect_s;
    logic [31:0]   target_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   seq_s;
    logic [31:0]   npc_raw_s;
    logic [31:0]   npc_s;

    // Handshake, redirect target and next-PC selection including the optional clamp
    always_comb begin
        redirect_s = JumpRegD | PCSrcD;
        target_s   = (JumpRegD ? JRTargetD : PCBranchD) & 32'hFFFF_FFFC;
        valid_s    = (count_r != {CW{1'b0}});
        pop_s      = valid_s & ReadyD;
        push_s     = !redirect_s & ((count_r < DEPTH_C) | pop_s);
        seq_s      = pc_r + 32'd4;
        npc_raw_s  = redirect_s ? target_s : seq_s;
        if (LIMIT_EN && (npc_raw_s >= PC_LIMIT)) begin
            npc_s = LOOP_PC;
        end else begin
            npc_s = npc_raw_s;
        end
    end

    // PC, pointers and occupancy; a redirect discards everything queued this cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (redirect_s) begin
                count_r  <= {CW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
            end
            if (redirect_s || push_s) begin
                pc_r <= npc_s;
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    // Queue payload storage; contents are only meaningful under count_r
    always_ff @(posedge CLK) begin
        if (!reset && push_s) begin
            instr_q[wr_ptr_r] <= ImemRD;
            pc4_q[wr_ptr_r]   <= seq_s;
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        if (valid_s) begin
            RDF      = instr_q[rd_ptr_r];
            PCPlus4F = pc4_q[rd_ptr_r];
        end else begin
            RDF      = 32'h0000_0000;
            PCPlus4F = 32'h0000_0000;
        end
    end

    assign InstrValidF = valid_s;
    assign QueueCount  = count_r;
    assign PCF         = pc_r;
    assign ImemAddr    = pc_r[IMEM_AW+1:2];

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage with an integrated prefetch queue.
- Owns the PC and drives an external combinational-read instruction memory.
- Buffers fetched {instruction, PC+4} pairs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake, replacing the fixed IF stage plus the IF/ID register.
- Takes jr and branch redirects from decode, flushes the queue on redirect, and has an optional PC-limit mode for simulation runs.

Parameters:
DEPTH, 2, queue entries; power of two, >= 2
IMEM_AW, 6, instruction-memory word-address width
RESET_PC, 32'h0, PC value after reset
LIMIT_EN, 0, 1 = enable PC-limit clamp
PC_LIMIT, 32'd84, any next-PC >= this value is replaced by LOOP_PC when LIMIT_EN=1
LOOP_PC, 32'd80, clamp target; word aligned, < PC_LIMIT

Ports:
CLK  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
PCSrcD  in  1  branch taken (decode)
JumpRegD  in  1  jr in decode; has priority over PCSrcD
PCBranchD  in  32  branch target
JRTargetD  in  32  jr target (rs value)
ImemAddr  out  IMEM_AW  word address = PCF[IMEM_AW+1:2]
ImemRD  in  32  instruction word, same-cycle combinational read
ReadyD  in  1  decode accepts head entry (inverse of StallD)
InstrValidF  out  1  head entry valid
RDF  out  32  head instruction
PCPlus4F  out  32  head PC+4
PCF  out  32  current fetch PC
QueueCount  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
Reset:
- When reset=1 at a clock edge: PCF<=RESET_PC, QueueCount<=0, read/write pointers <=0.
- After reset: InstrValidF=0; RDF and PCPlus4F=0 while empty (outputs are forced to 0 when empty).
- Reset mid-operation discards all entries and any concurrent redirect; reset wins over everything.

Signals:
- redirect = JumpRegD | PCSrcD.
- target = JumpRegD ? JRTargetD : PCBranchD, with bits [1:0] forced to 0.
- pop = InstrValidF & ReadyD.
- push = !redirect & (QueueCount<DEPTH | pop).

Next-PC:
- seq = PCF+4, mod 2^32.
- npc = redirect ? target : seq.
- If LIMIT_EN and npc >= PC_LIMIT (unsigned), npc = LOOP_PC.
- PCF <= npc when (redirect | push); otherwise PCF holds.

Queue:
- Push writes {ImemRD, PCF+4} at the tail.
- Head is registered storage, so a fetched word is visible on RDF at the earliest one cycle after its fetch. No combinational bypass.
- Push and pop in the same cycle (including when full): count unchanged, both pointers advance.
- Pop with no push: count-1. Push with no pop: count+1. Pointers wrap modulo DEPTH.
- Full with no pop: no push, PC holds; the same address is re-read next cycle.

Redirect:
- Flushes the queue (count<=0, pointers <=0) and ignores any pop in that cycle.
- The instruction at the PCF being fetched is dropped; PCF<=npc.
- The target instruction reaches InstrValidF=1 two edges after the redirect edge: cycle+1 fetches it, cycle+2 presents it.
- Both JumpRegD and PCSrcD high: JRTargetD is used.

Outputs:
- InstrValidF = (QueueCount!=0).
- Outputs are stable while InstrValidF=1 and ReadyD=0.

Test Plan:
- Reset then ReadyD=1, ImemRD=addr-indexed pattern -> ImemAddr 0,1,2,...; first InstrValidF=1 one cycle after reset release with RDF=mem[0], PCPlus4F=4; one entry per cycle thereafter.
- ReadyD=0 for 5 cycles, DEPTH=2 -> QueueCount rises to 2 then holds, PCF stalls at 8, RDF stays mem[0]; ReadyD=1 -> mem[0], mem[1], mem[2] delivered in order with no loss or duplicate.
- PCSrcD=1, PCBranchD=0x40 with 2 entries queued -> next cycle QueueCount=0, InstrValidF=0, PCF=0x40; following cycle RDF=mem[16], PCPlus4F=0x44.
- JumpRegD=1 with JRTargetD=0x23 and PCSrcD=1 with PCBranchD=0x10 in the same cycle -> PCF=0x20; the branch is ignored.
- LIMIT_EN=1 (84/80) free-running with ReadyD=1 -> PCF sequence ..., 76, 80, 80, 80; RDF repeats mem[20]. A redirect to 0x60 is clamped to PCF=80.
- Reset asserted while full and during a redirect -> next cycle PCF=RESET_PC, QueueCount=0, InstrValidF=0.
